// File: rtl/i2s_dac_tx_if.sv
// Sample hand-off between the generator stage and the I2S DAC transmitter.
// The generator drives samples and the transmitter reports frame timing and buffer status.
interface i2s_dac_tx_if #(
    parameter int DATA_W = 24
);
    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_valid;
    logic                     frame_req;
    logic                     underrun;
    logic                     overrun;

    modport master (
        output sample_in,
        output sample_valid,
        input  frame_req,
        input  underrun,
        input  overrun
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output frame_req,
        output underrun,
        output overrun
    );
endinterface

// File: rtl/i2s_dac_tx.sv
// Mono I2S transmitter: double-buffers one sample per frame, derives BCLK/LRCK from clk_fast,
// and sends the sample MSB-first in both the left and right slots with the standard one-bit delay.
module i2s_dac_tx #(
    parameter int BCLK_DIV = 4,
    parameter int DATA_W   = 24
) (
    input  logic         clk_fast,
    input  logic         rst,
    i2s_dac_tx_if.slave  smp,
    output logic         aud_bclk,
    output logic         aud_daclrck,
    output logic         aud_dacdat
);
    localparam int DIV_W = $clog2(BCLK_DIV);

    logic [DIV_W-1:0]         div_q, div_d;
    logic                     bclk_q;
    logic [5:0]               bit_q, bit_d;
    logic                     lrck_q;
    logic                     dat_q;
    logic signed [DATA_W-1:0] hold_q;
    logic                     full_q;
    logic signed [DATA_W-1:0] frame_q;

    logic div_wrap;
    logic fall;
    logic latch;

    // Bit of the word for slot s; slot 0 is the I2S delay bit and slots past the word are padding.
    function automatic logic slot_bit(input logic [4:0] s, input logic [DATA_W-1:0] w);
        int                si;
        logic [DATA_W-1:0] sh;
        si = int'(s);
        if (si >= 1 && si <= DATA_W) begin
            sh = w << (si - 1);
            return sh[DATA_W-1];
        end
        return 1'b0;
    endfunction

    always_comb begin
        div_wrap = (div_q == DIV_W'(BCLK_DIV - 1));
        div_d    = div_wrap ? '0 : div_q + 1'b1;
        fall     = div_wrap & bclk_q;
        latch    = fall & (bit_q == 6'd63);
        bit_d    = bit_q + 6'd1;
    end

    assign smp.frame_req = latch;
    assign smp.underrun  = latch & ~smp.sample_valid & ~full_q;
    assign smp.overrun   = smp.sample_valid & full_q & ~latch;

    assign aud_bclk    = bclk_q;
    assign aud_daclrck = lrck_q;
    assign aud_dacdat  = dat_q;

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            div_q   <= '0;
            bclk_q  <= 1'b0;
            bit_q   <= 6'd63;
            lrck_q  <= 1'b0;
            dat_q   <= 1'b0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            frame_q <= '0;
        end else begin
            div_q <= div_d;
            if (div_wrap) begin
                bclk_q <= ~bclk_q;
            end

            // Serial outputs move on BCLK falling edges so the codec sees them stable on the rise.
            if (fall) begin
                bit_q  <= bit_d;
                lrck_q <= bit_d[5];
                dat_q  <= slot_bit(bit_d[4:0], frame_q);
            end

            if (smp.sample_valid) begin
                hold_q <= smp.sample_in;
            end

            // A strobe coinciding with the latch bypasses the holding register.
            if (latch) begin
                full_q <= 1'b0;
                if (smp.sample_valid) begin
                    frame_q <= smp.sample_in;
                end else if (full_q) begin
                    frame_q <= hold_q;
                end
            end else if (smp.sample_valid) begin
                full_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_i2s_dac_tx.sv
// Randomised and directed bench for i2s_dac_tx with a frame-level reference model and scoreboard.
module tb_i2s_dac_tx;
    localparam int D     = 4;
    localparam int FRAME = 128 * D;
    localparam int FIRST = 2 * D - 1;

    logic clk_fast = 1'b0;
    logic rst;
    logic aud_bclk, aud_daclrck, aud_dacdat;

    i2s_dac_tx_if #(.DATA_W(24)) bus ();

    i2s_dac_tx #(.BCLK_DIV(D), .DATA_W(24)) dut (
        .clk_fast    (clk_fast),
        .rst         (rst),
        .smp         (bus),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .aud_dacdat  (aud_dacdat)
    );

    always #5 clk_fast = ~clk_fast;

    // Cycles since reset release; cycle k is the period before the k-th rising edge.
    int cyc;
    always @(posedge clk_fast) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_words[$];
    int          und_q[$];
    int          ovr_q[$];
    bit          pending;
    logic [23:0] pend_val;
    logic [23:0] cur_word;

    function automatic bit is_latch(input int k);
        return (k >= FIRST) && (((k - FIRST) % FRAME) == 0);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one word per frame, newest sample wins, missing sample repeats the last word.
    task automatic step(input bit v, input logic [23:0] d);
        int k;
        bit lat;
        k   = cyc;
        lat = is_latch(k);
        bus.sample_valid = v;
        bus.sample_in    = d;
        if (lat) begin
            if (v)            cur_word = d;
            else if (pending) cur_word = pend_val;
            else              und_q.push_back(k);
            pending = 1'b0;
            exp_words.push_back(cur_word);
        end else if (v) begin
            if (pending) ovr_q.push_back(k);
            pending  = 1'b1;
            pend_val = d;
        end
        @(negedge clk_fast);
    endtask

    task automatic idle_to(input int c);
        while (cyc < c) step(1'b0, 24'h0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        pending  = 1'b0;
        cur_word = '0;
        exp_words.delete();
        und_q.delete();
        ovr_q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk_fast);
            check("reset_outputs",
                  {aud_bclk, aud_daclrck, aud_dacdat, bus.frame_req, bus.underrun, bus.overrun},
                  6'b0);
        end
        rst = 1'b0;
    endtask

    // Monitor: per-cycle pulse checks plus a codec-style capture on every BCLK rise.
    initial begin
        bit          prev;
        int          rises;
        int          k;
        bit          e;
        logic [5:0]  p;
        logic [4:0]  s;
        logic [63:0] lv, dv, el, ed;
        logic [23:0] w;
        prev  = 1'b0;
        rises = 0;
        lv = '0; dv = '0;
        forever begin
            @(negedge clk_fast);
            #2;
            if (rst) begin
                prev  = 1'b0;
                rises = 0;
            end else begin
                k = cyc;
                check("bclk", aud_bclk, (k / D) % 2);
                e = is_latch(k);
                if (e || bus.frame_req) check("frame_req", bus.frame_req, e);
                e = (und_q.size() > 0) && (und_q[0] == k);
                if (e) void'(und_q.pop_front());
                if (e || bus.underrun) check("underrun", bus.underrun, e);
                e = (ovr_q.size() > 0) && (ovr_q[0] == k);
                if (e) void'(ovr_q.pop_front());
                if (e || bus.overrun) check("overrun", bus.overrun, e);
                if (aud_bclk && !prev) begin
                    if (rises >= 1) begin
                        p = 6'((rises - 1) % 64);
                        if (p == 6'd0) begin
                            lv = '0;
                            dv = '0;
                        end
                        lv[p] = aud_daclrck;
                        dv[p] = aud_dacdat;
                        if (p == 6'd63) begin
                            if (exp_words.size() == 0) begin
                                check("frame_word_expected", 1'b0, 1'b1);
                            end else begin
                                w = exp_words.pop_front();
                                for (int i = 0; i < 64; i++) begin
                                    s = 5'(i % 32);
                                    el[i] = (i >= 32);
                                    ed[i] = (s >= 5'd1 && s <= 5'd24) ? w[24 - int'(s)] : 1'b0;
                                end
                                check("frame_bits", {lv, dv}, {el, ed});
                            end
                        end
                    end
                    rises++;
                end
                prev = aud_bclk;
            end
        end
    end

    initial begin
        bit v;
        rst = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        pending  = 1'b0;
        pend_val = '0;
        cur_word = '0;
        @(negedge clk_fast);
        do_reset(10);

        idle_to(100);  step(1'b1, 24'hABCDEF);
        idle_to(600);  step(1'b1, 24'h800000);
        idle_to(1100); step(1'b1, 24'h7FFFFF);
        idle_to(1600); step(1'b1, 24'h111111);
        idle_to(1700); step(1'b1, 24'h222222);
        idle_to(2400); step(1'b1, 24'h333333);
        idle_to(FIRST + 5 * FRAME); step(1'b1, 24'h5A5A5A);

        while (cyc < FIRST + 11 * FRAME) begin
            v = ($urandom_range(0, 399) == 0) || (is_latch(cyc) && ($urandom_range(0, 2) == 0));
            step(v, 24'($urandom));
        end

        idle_to(FIRST + 11 * FRAME + 100); step(1'b1, 24'hC3C3C3);
        idle_to(FIRST + 11 * FRAME + 8 * 40 + 3);
        do_reset(1);

        idle_to(300); step(1'b1, 24'h0F0F0F);
        idle_to(FIRST + 2 * FRAME + 80);

        check("underrun_all_seen", und_q.size(), 0);
        check("overrun_all_seen", ovr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
